// File: rtl/pipelined_control_sequencer.sv
// Phase FSM and decoder for the 16-bit CPU: fetch/exec1/exec2/mulwait/halt, register, PC, memory and stack controls.
// Ports: clk, rst_n, instr, instr_valid, eq, jmr_cond in; phase flags, enables, stack controls out. Option macro: STACK_GUARD_EN.
module pipelined_control_sequencer #(
  parameter int MUL_LAT     = 2,
  parameter int STACK_DEPTH = 8,
  parameter int SAW         = $clog2(STACK_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    instr,
  input  logic           instr_valid,
  input  logic           eq,
  input  logic           jmr_cond,
  output logic           fe,
  output logic           e1,
  output logic           e2,
  output logic           mul_wait,
  output logic           halted,
  output logic [3:0]     reg_wen,
  output logic           pc_cnten,
  output logic           pc_sload,
  output logic [1:0]     pcmux_sel,
  output logic           data_wren,
  output logic           mul_start,
  output logic           push_en,
  output logic           pop_en,
  output logic [SAW-1:0] stack_addr,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           stack_fault
);

  typedef enum logic [2:0] {
    FETCH, EXEC1, EXEC2, MULW, HALT
  } state_t;

  localparam logic [3:0]   MUL_LAT_M1 = 4'(MUL_LAT - 1);
  localparam logic [SAW:0] DEPTH_C    = (SAW+1)'(STACK_DEPTH);
  localparam logic [SAW:0] ONE_C      = (SAW+1)'(1);

  state_t       state_q, state_d;
  logic [3:0]   mcnt_q, mcnt_d;
  logic [SAW:0] cnt_q, cnt_d;

  logic [4:0] op;
  logic op_stp, op_adr, op_adm, op_adi, op_sbr, op_sbm;
  logic op_sbi, op_mlr, op_xsl, op_xsr, op_bbo, op_stk;
  logic op_ldr, op_sti, op_ldi, op_sta, op_lda;
  logic op_jmr, op_jmp, op_jeq, op_jnq;
  logic two_cyc, push_req, pop_req, push_ok, pop_ok;
  logic pop_pc, guard_trip;
  logic [SAW:0] cnt_m1;
  logic [1:0] dst;
  logic       wr;
  logic       unused;

  assign op     = instr[15:11];
  assign op_stp = (op == 5'b00000);
  assign op_adr = (op == 5'b00001);
  assign op_adm = (op[4:1] == 4'b0001);
  assign op_adi = (op == 5'b00100);
  assign op_sbr = (op == 5'b00101);
  assign op_sbm = (op[4:1] == 4'b0011);
  assign op_sbi = (op == 5'b01000);
  assign op_mlr = (op == 5'b01001);
  assign op_xsl = (op == 5'b01010);
  assign op_xsr = (op == 5'b01011);
  assign op_bbo = (op == 5'b01100);
  assign op_stk = (op == 5'b01101);
  assign op_ldr = (op == 5'b01110);
  assign op_sti = (op == 5'b01111);
  assign op_ldi = (op[4:2] == 3'b100);
  assign op_sta = (op[4:2] == 3'b101);
  assign op_lda = (op[4:2] == 3'b110);
  assign op_jmr = (op == 5'b11100);
  assign op_jmp = (op == 5'b11101);
  assign op_jeq = (op == 5'b11110);
  assign op_jnq = (op == 5'b11111);

  // Operand fields not consumed by this unit.
  assign unused = ^{instr[5:4], instr[1:0]};

  assign fe       = (state_q == FETCH);
  assign e1       = (state_q == EXEC1);
  assign e2       = (state_q == EXEC2);
  assign mul_wait = (state_q == MULW);
  assign halted   = (state_q == HALT);

  assign stack_empty = (cnt_q == '0);
  assign stack_full  = (cnt_q == DEPTH_C);
  assign cnt_m1      = cnt_q - ONE_C;

  assign two_cyc  = op_adm | op_sbm | op_lda | op_ldr;
  assign push_req = e1 & op_stk & ~instr[10];
  assign pop_req  = e1 & op_stk & instr[10];
  assign push_ok  = push_req & ~stack_full;
  assign pop_ok   = pop_req & ~stack_empty;
  assign pop_pc   = instr[9] & ~instr[8] & ~instr[7];

`ifdef STACK_GUARD_EN
  logic fault_q;
  assign guard_trip  = (push_req & stack_full)
                     | (pop_req & stack_empty);
  assign stack_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else if (guard_trip) fault_q <= 1'b1;
  end
`else
  assign guard_trip  = 1'b0;
  assign stack_fault = 1'b0;
`endif

  assign push_en   = push_ok;
  assign pop_en    = pop_ok;
  assign data_wren = e1 & (op_sta | op_sti);
  assign mul_start = e1 & op_mlr;

  // Reset forces FETCH, but the PC must not advance while held.
  assign pc_cnten = rst_n & (fe | e2 |
    (e1 & ~(op_stp | two_cyc | op_mlr)));

  assign pc_sload = e1 & (op_jmp | (op_jeq & eq) |
    (op_jnq & ~eq) | (op_jmr & jmr_cond) |
    (op_stk & instr[10] & pop_pc & ~stack_empty));

  always_comb begin
    pcmux_sel = 2'b00;
    if (e1 & op_jmr) pcmux_sel = 2'b01;
    else if (e1 & op_stk & instr[10] & pop_pc)
      pcmux_sel = 2'b10;
  end

  always_comb begin
    if (push_ok) stack_addr = cnt_q[SAW-1:0];
    else if (stack_empty) stack_addr = '0;
    else stack_addr = cnt_m1[SAW-1:0];
  end

  always_comb begin
    dst = 2'b00;
    wr  = 1'b0;
    unique case (1'b1)
      e1 & op_ldi: begin
        wr = 1'b1; dst = instr[12:11];
      end
      e1 & (op_adr | op_sbr | op_xsl | op_xsr | op_bbo): begin
        wr = 1'b1; dst = instr[3:2];
      end
      e1 & (op_adi | op_sbi): begin
        wr = 1'b1; dst = instr[10:9];
      end
      pop_ok & ~instr[9]: begin
        wr = 1'b1; dst = instr[7:6];
      end
      e2 & op_lda: begin
        wr = 1'b1; dst = instr[12:11];
      end
      e2 & op_ldr: begin
        wr = 1'b1; dst = instr[10:9];
      end
      e2 & op_mlr: begin
        wr = 1'b1; dst = instr[3:2];
      end
      e2 & (op_adm | op_sbm): begin
        wr = 1'b1; dst = {1'b0, instr[11]};
      end
      default: ;
    endcase
  end

  assign reg_wen = {4{wr}} & (4'b0001 << dst);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok) cnt_d = cnt_q + ONE_C;
    else if (pop_ok) cnt_d = cnt_m1;
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      FETCH: if (instr_valid) state_d = EXEC1;
      EXEC1: begin
        if (op_stp | guard_trip) state_d = HALT;
        else if (two_cyc) state_d = EXEC2;
        else if (op_mlr) begin
          if (MUL_LAT == 1) state_d = EXEC2;
          else begin
            state_d = MULW;
            mcnt_d  = MUL_LAT_M1;
          end
        end
        else state_d = FETCH;
      end
      // Counter loaded with MUL_LAT-1; leave on the last wait cycle.
      MULW: begin
        mcnt_d = mcnt_q - 4'd1;
        if (mcnt_q == 4'd1) state_d = EXEC2;
      end
      EXEC2: state_d = FETCH;
      HALT:  state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      mcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
